// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] PC_STEP              = 32'(INSTR_BYTES);
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Branch targets are always fetched on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: holds the PC, issues one memory request at a time,
// presents the fetched word to decode and handles redirects at any point of a fetch.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_plus4,
  output logic [31:0] adder_in1,
  output logic [31:0] adder_in2,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         kill_q, kill_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  target;

  assign target = word_align(redirect_pc);

  // addr_q is the address of the outstanding request; it diverges from pc_q only while
  // a killed request is still waiting for its ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    kill_d     = kill_q;
    misalign_d = redirect && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) begin
          pc_d   = target;
          addr_d = target;
        end else begin
          addr_d = pc_q;
        end
      end

      ST_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d   = target;
            addr_d = target;
            kill_d = 1'b0;
          end else if (kill_q) begin
            // Stale response: drop it and re-issue at the redirected PC.
            addr_d = pc_q;
            kill_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_DELIVER;
          end
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end

      ST_DELIVER: begin
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  assign adder_in1   = pc_q;
  assign adder_in2   = PC_STEP;
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == ST_DELIVER);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule
